if_block: RTL

Instruction-fetch stage of the mips32 five-stage pipeline, producing the IF/ID contents that the decode stage consumes. It owns the PC and applies next-PC selection and flush/stall commands coming back from decode and the hazard unit. It talks to a variable-latency instruction memory over a req/ready handshake, so redirects and stalls that arrive while a fetch is outstanding are resolved here.

---
 rtl/mips32_pkg.sv | 37 +++
 rtl/if_block_if_id_stage.sv | 38 +++
 rtl/if_block.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mips32_pkg.sv
// Shared definitions for the mips32 pipeline: next-PC select codes, fetch FSM states, bubble word.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips32_pkg;

  // ID_PCSrc encodings
  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_JR     = 2'b11;

  // Instruction word used for bubbles in IF/ID
  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2,
    S_HELD  = 2'd3
  } fetchStateT;

  // Redirect target for a non-sequential PCSrc; PCSRC_SEQ never reaches a redirect.
  function automatic logic [31:0] selectTarget(input logic [1:0]  pcSrc,
                                               input logic [31:0] branchAddr,
                                               input logic [31:0] jumpAddr,
                                               input logic [31:0] jrRsData);
    logic [31:0] t;
    t = branchAddr;
    case (pcSrc)
      PCSRC_JUMP: t = jumpAddr;
      PCSRC_JR:   t = jrRsData;
      default:    t = branchAddr;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/if_block_if_id_stage.sv
// IF/ID pipeline register: loads a fetched word, or a bubble when flushed or nothing was fetched.
// Latency: 1 cycle (registered on Clock).
// Backpressure: wrEn low (hazard stall) holds every field, and takes priority over flush.
// Ports: wrEn, flush, load (instrIn/pcPlus4In valid) in; instr, pcPlus4, valid out.
module IF_ID_Stage
  import mips32_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic        wrEn,
  input  logic        flush,
  input  logic        load,
  input  logic [31:0] instrIn,
  input  logic [31:0] pcPlus4In,
  output logic [31:0] instr,
  output logic [31:0] pcPlus4,
  output logic        valid
);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      instr   <= NOP;
      pcPlus4 <= 32'h0000_0000;
      valid   <= 1'b0;
    end else if (wrEn) begin
      if (load && !flush) begin
        instr   <= instrIn;
        pcPlus4 <= pcPlus4In;
        valid   <= 1'b1;
      end else begin
        // Bubble keeps the previous PC+4 so decode still sees a sane value.
        instr <= NOP;
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/if_block.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready memory port, fills IF/ID.
// Latency: zero-wait memory gives one instruction per cycle; IF/ID updates on the edge Ready is sampled.
// Backpressure: HazZero holds PC and IF/ID; a word that arrives during a stall is kept in a skid buffer.
// Ports: ID_PCSrc/targets, IF_Flush, HazZero from decode/hazard; IMem_* memory port; ID_* IF/ID outputs; FetchStall.
module if_block
  import mips32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [1:0]  ID_PCSrc,
  input  logic [31:0] ID_BranchAddr,
  input  logic [31:0] ID_JumpAddr,
  input  logic [31:0] ID_JrRsData,
  input  logic        IF_Flush,
  input  logic        HazZero,
  output logic        IMem_Req,
  output logic [31:0] IMem_Addr,
  input  logic        IMem_Ready,
  input  logic [31:0] IMem_RData,
  output logic [31:0] ID_Instruction,
  output logic [31:0] ID_PCplus4,
  output logic        ID_Valid,
  output logic        FetchStall
);

  fetchStateT  state;
  logic [31:0] pc;
  logic [31:0] savedTarget;
  logic [31:0] skidBuf;

  logic        advance;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] pcPlus4;
  logic        ifidLoad;
  logic [31:0] ifidInstr;

  assign advance  = !HazZero;
  assign redirect = (ID_PCSrc != PCSRC_SEQ) && !HazZero;
  assign target   = selectTarget(ID_PCSrc, ID_BranchAddr, ID_JumpAddr, ID_JrRsData);
  assign pcPlus4  = pc + 32'd4;

  assign IMem_Req   = (state == S_REQ) || (state == S_DRAIN);
  assign IMem_Addr  = pc;
  assign FetchStall = (state == S_IDLE) || (state == S_DRAIN) ||
                      ((state == S_REQ) && !IMem_Ready);

  // A real instruction is available only from a completed fetch or the skid
  // buffer, and never when decode redirects in the same cycle.
  always_comb begin
    ifidLoad  = 1'b0;
    ifidInstr = IMem_RData;
    case (state)
      S_REQ:   ifidLoad = IMem_Ready && !redirect;
      S_HELD: begin
        ifidLoad  = !redirect;
        ifidInstr = skidBuf;
      end
      default: ifidLoad = 1'b0;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      savedTarget <= RESET_PC;
      skidBuf     <= NOP;
    end else begin
      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (IMem_Ready) begin
            if (redirect) begin
              pc <= target;
            end else if (advance) begin
              pc <= pcPlus4;
            end else begin
              skidBuf <= IMem_RData;
              state   <= S_HELD;
            end
          end else if (redirect) begin
            // Address must stay stable until the outstanding fetch completes.
            savedTarget <= target;
            state       <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (IMem_Ready) begin
            // A redirect landing on the completing edge is the newest target.
            pc    <= redirect ? target : savedTarget;
            state <= S_REQ;
          end else if (redirect) begin
            savedTarget <= target;
          end
        end
        S_HELD: begin
          if (advance) begin
            pc    <= redirect ? target : pcPlus4;
            state <= S_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  IF_ID_Stage u_ifId (
    .Clock     (Clock),
    .Reset     (Reset),
    .wrEn      (advance),
    .flush     (IF_Flush),
    .load      (ifidLoad),
    .instrIn   (ifidInstr),
    .pcPlus4In (pcPlus4),
    .instr     (ID_Instruction),
    .pcPlus4   (ID_PCplus4),
    .valid     (ID_Valid)
  );

endmodule
